// File: rtl/program_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package risc_loader_pkg;

    localparam int unsigned WORD_SIZE = 8;
    localparam int unsigned ADDR_SIZE = 8;

    // Loader FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // One SRAM write beat
    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } mem_wr_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake plus SRAM write port of the program loader.
interface program_loader_if;
    import risc_loader_pkg::*;

    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_ready;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 mem_write;

    // Environment side: sources the stream, observes the SRAM writes
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_write
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_write
    );

endinterface

// File: rtl/program_loader.sv
// Boot loader: parses LEN / payload / CSUM frames, writes the payload to SRAM
// and releases the processor reset only after a good checksum.
module program_loader
    import risc_loader_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] LOAD_BASE = ADDR_SIZE'(0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    program_loader_if.slave   bus,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] remaining_q, remaining_d;
    logic [ADDR_SIZE-1:0] index_q, index_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    mem_wr_t              mem_wr_q, mem_wr_d;
    logic                 mem_write_q, mem_write_d;
    logic                 cpu_rst_n_q, cpu_rst_n_d;
    logic                 load_done_q, load_done_d;
    logic                 load_err_q, load_err_d;
    logic                 in_ready_c;
    logic                 xfer_c;

    // Ready is a pure state decode so it never waits on in_valid
    assign in_ready_c = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer_c     = bus.in_valid && in_ready_c;

    // Next-state, frame bookkeeping and registered-output inputs
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        acc_d       = acc_q;
        mem_wr_d    = mem_wr_q;
        mem_write_d = 1'b0;

        if (reload) begin
            // Restart wins over any byte offered in the same cycle
            state_d     = S_LEN;
            remaining_d = '0;
            index_d     = '0;
            acc_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_LEN;
                S_LEN: begin
                    if (xfer_c) begin
                        if (bus.in_data == '0) begin
                            state_d = S_ERR;
                        end else begin
                            remaining_d = bus.in_data;
                            acc_d       = '0;
                            index_d     = '0;
                            state_d     = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_c) begin
                        mem_write_d   = 1'b1;
                        mem_wr_d.addr = LOAD_BASE + index_q;
                        mem_wr_d.data = bus.in_data;
                        acc_d         = acc_q + bus.in_data;
                        index_d       = index_q + ADDR_SIZE'(1);
                        remaining_d   = remaining_q - WORD_SIZE'(1);
                        if (remaining_q == WORD_SIZE'(1)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer_c) begin
                        state_d = (WORD_SIZE'(acc_q + bus.in_data) == '0) ? S_RUN : S_ERR;
                    end
                end
                S_RUN, S_ERR: begin
                    state_d = state_q;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Status follows the state being entered, giving one-cycle latency
        cpu_rst_n_d = (state_d == S_RUN);
        load_done_d = (state_d == S_RUN);
        load_err_d  = (state_d == S_ERR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            acc_q       <= '0;
            mem_wr_q    <= '0;
            mem_write_q <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            acc_q       <= acc_d;
            mem_wr_q    <= mem_wr_d;
            mem_write_q <= mem_write_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_addr  = mem_wr_q.addr;
    assign bus.mem_data  = mem_wr_q.data;
    assign bus.mem_write = mem_write_q;
    assign cpu_rst_n     = cpu_rst_n_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (load base 00 and FE) share one
// stream; a frame-level model predicts writes, memory image and status.
module tb_program_loader;
    import risc_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       reload;
    logic       in_valid;
    logic [7:0] in_data;
    logic       cpu_rst_n_a, load_done_a, load_err_a;
    logic       cpu_rst_n_b, load_done_b, load_err_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // SRAM images captured from the write ports, and write counters
    logic [7:0] sram_a [256];
    logic [7:0] sram_b [256];
    int         wr_a = 0;
    int         wr_b = 0;

    // Model memory image
    logic [7:0] exp_a [256];
    logic [7:0] exp_b [256];
    bit         touched [256];

    logic [7:0] q [$];

    always #5 clk = ~clk;

    program_loader_if if_a ();
    program_loader_if if_b ();

    assign if_a.in_valid = in_valid;
    assign if_a.in_data  = in_data;
    assign if_b.in_valid = in_valid;
    assign if_b.in_data  = in_data;

    program_loader #(.LOAD_BASE(8'h00)) dut_a (
        .clk(clk), .rst(rst), .reload(reload), .bus(if_a.slave),
        .cpu_rst_n(cpu_rst_n_a), .load_done(load_done_a), .load_err(load_err_a)
    );

    program_loader #(.LOAD_BASE(8'hFE)) dut_b (
        .clk(clk), .rst(rst), .reload(reload), .bus(if_b.slave),
        .cpu_rst_n(cpu_rst_n_b), .load_done(load_done_b), .load_err(load_err_b)
    );

    // SRAM behaviour: capture a write on each strobed rising edge
    always @(posedge clk) begin
        if (if_a.mem_write) begin
            sram_a[if_a.mem_addr] <= if_a.mem_data;
            wr_a <= wr_a + 1;
        end
        if (if_b.mem_write) begin
            sram_b[if_b.mem_addr] <= if_b.mem_data;
            wr_b <= wr_b + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish before 500us");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_wr(input logic [7:0] off, input logic [7:0] d);
        logic [7:0] ab;
        ab = 8'hFE + off;
        exp_a[off]  = d;
        exp_b[ab]   = d;
        touched[off] = 1'b1;
    endtask

    // Offer one byte from a negedge, wait for its transfer, then check the
    // write port in the cycle right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_wr,
                             input logic [7:0] off, input logic [7:0] d);
        int         waited;
        logic [7:0] ab;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!if_a.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 32'(waited < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mem_write_a", 32'(if_a.mem_write), 32'(exp_wr));
        chk("mem_write_b", 32'(if_b.mem_write), 32'(exp_wr));
        if (exp_wr) begin
            ab = 8'hFE + off;
            chk("mem_addr_a", 32'(if_a.mem_addr), 32'(off));
            chk("mem_data_a", 32'(if_a.mem_data), 32'(d));
            chk("mem_addr_b", 32'(if_b.mem_addr), 32'(ab));
            chk("mem_data_b", 32'(if_b.mem_data), 32'(d));
        end
    endtask

    // Send a whole frame with gmin..gmax idle cycles before each later byte
    task automatic send_frame(input logic [7:0] fr[$], input int gmin, input int gmax);
        int         len;
        int         nb;
        int         w0a;
        int         w0b;
        logic [7:0] s;
        bit         good;
        len = int'(fr[0]);
        nb  = (len == 0) ? 1 : len + 2;
        w0a = wr_a;
        w0b = wr_b;
        s   = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(gmax, gmin)) begin
                    @(negedge clk);
                    chk("idle_no_write", 32'(if_a.mem_write), 32'd0);
                end
            end
            if (i >= 1 && i <= len) begin
                send_byte(fr[i], 1'b1, 8'(i - 1), fr[i]);
                model_wr(8'(i - 1), fr[i]);
                s = s + fr[i];
            end else begin
                send_byte(fr[i], 1'b0, 8'h00, 8'h00);
            end
        end
        good = (len != 0) && (8'(s + fr[nb-1]) == 8'h00);
        chk("cpu_rst_n_a", 32'(cpu_rst_n_a), 32'(good));
        chk("load_done_a", 32'(load_done_a), 32'(good));
        chk("load_err_a",  32'(load_err_a),  32'(!good));
        chk("cpu_rst_n_b", 32'(cpu_rst_n_b), 32'(good));
        chk("load_err_b",  32'(load_err_b),  32'(!good));
        chk("in_ready_end", 32'(if_a.in_ready), 32'd0);
        chk("write_count_a", 32'(wr_a - w0a), 32'(len));
        chk("write_count_b", 32'(wr_b - w0b), 32'(len));
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
        chk("reload_ready", 32'(if_a.in_ready), 32'd1);
        chk("reload_cpu_rst_n", 32'(cpu_rst_n_a), 32'd0);
        chk("reload_done", 32'(load_done_a), 32'd0);
        chk("reload_err", 32'(load_err_b), 32'd0);
        chk("reload_write", 32'(if_a.mem_write), 32'd0);
    endtask

    initial begin
        int         len;
        int         mism;
        logic [7:0] s;
        logic [7:0] cs;
        logic [7:0] b;

        rst      = 1'b0;
        reload   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_in_ready",  32'(if_a.in_ready),  32'd0);
        chk("rst_mem_write", 32'(if_a.mem_write), 32'd0);
        chk("rst_mem_addr",  32'(if_b.mem_addr),  32'd0);
        chk("rst_mem_data",  32'(if_a.mem_data),  32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n_a),    32'd0);
        chk("rst_load_done", 32'(load_done_a),    32'd0);
        chk("rst_load_err",  32'(load_err_a),     32'd0);

        rst = 1'b1;
        chk("idle_not_ready", 32'(if_a.in_ready), 32'd0);
        @(negedge clk);
        chk("len_ready", 32'(if_a.in_ready), 32'd1);

        // Good load, back-to-back
        q = {8'h03, 8'h51, 8'h02, 8'h70, 8'h3D};
        send_frame(q, 0, 0);

        // Bad checksum, then reload and a good frame
        do_reload();
        q = {8'h03, 8'h51, 8'h02, 8'h70, 8'h3E};
        send_frame(q, 0, 0);
        do_reload();
        q = {8'h03, 8'h51, 8'h02, 8'h70, 8'h3D};
        send_frame(q, 0, 0);

        // Zero length
        do_reload();
        q = {8'h00};
        send_frame(q, 0, 0);

        // Wrap frame (FE, FF, 00 on the FE-based instance)
        do_reload();
        q = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send_frame(q, 0, 0);

        // Two idle cycles between bytes
        do_reload();
        q = {8'h03, 8'h51, 8'h02, 8'h70, 8'h3D};
        send_frame(q, 2, 2);

        // Reload mid-payload together with a valid byte
        do_reload();
        send_byte(8'h05, 1'b0, 8'h00, 8'h00);
        send_byte(8'hAA, 1'b1, 8'h00, 8'hAA);
        model_wr(8'h00, 8'hAA);
        send_byte(8'hBB, 1'b1, 8'h01, 8'hBB);
        model_wr(8'h01, 8'hBB);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        reload   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        chk("midreload_ready",     32'(if_a.in_ready),  32'd1);
        chk("midreload_cpu_rst_n", 32'(cpu_rst_n_a),    32'd0);
        chk("midreload_write",     32'(if_a.mem_write), 32'd0);
        chk("midreload_err",       32'(load_err_a),     32'd0);
        q = {8'h02, 8'h10, 8'h20, 8'hD0};
        send_frame(q, 0, 0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            do_reload();
            q.delete();
            if ($urandom_range(7, 0) == 0) begin
                q.push_back(8'h00);
            end else begin
                len = int'($urandom_range(12, 1));
                q.push_back(8'(len));
                s = 8'h00;
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(255, 0));
                    q.push_back(b);
                    s = s + b;
                end
                cs = 8'h00 - s;
                if ($urandom_range(3, 0) == 0) begin
                    cs = cs + 8'($urandom_range(255, 1));
                end
                q.push_back(cs);
            end
            send_frame(q, 0, 2);
        end

        // Async reset during payload: pending strobe for the second byte is lost
        do_reload();
        send_byte(8'h04, 1'b0, 8'h00, 8'h00);
        send_byte(8'h5A, 1'b1, 8'h00, 8'h5A);
        send_byte(8'hA5, 1'b1, 8'h01, 8'hA5);
        model_wr(8'h00, 8'h5A);
        rst = 1'b0;
        #1;
        chk("arst_mem_write", 32'(if_a.mem_write), 32'd0);
        chk("arst_mem_addr",  32'(if_b.mem_addr),  32'd0);
        chk("arst_mem_data",  32'(if_a.mem_data),  32'd0);
        chk("arst_in_ready",  32'(if_a.in_ready),  32'd0);
        chk("arst_cpu_rst_n", 32'(cpu_rst_n_a),    32'd0);
        chk("arst_load_done", 32'(load_done_a),    32'd0);
        chk("arst_load_err",  32'(load_err_a),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("arst_idle_ready", 32'(if_a.in_ready), 32'd0);
        @(negedge clk);
        chk("arst_len_ready", 32'(if_a.in_ready), 32'd1);
        q = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send_frame(q, 0, 1);

        // Final memory image against the model
        @(negedge clk);
        mism = 0;
        for (int a = 0; a < 256; a++) begin
            if (touched[a]) begin
                if (sram_a[a] !== exp_a[a]) mism++;
                if (sram_b[8'(a + 254)] !== exp_b[8'(a + 254)]) mism++;
            end
        end
        chk("mem_image", 32'(mism), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
